// File: rtl/handshake_sink_pkg.sv
// Shared definitions for the handshake token sink: FSM state encoding,
// default counter width and the saturating increment used by every counter.
package handshake_sink_pkg;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        HOLD   = 2'd1,
        DONE   = 2'd2
    } sink_state_t;

    localparam int unsigned DEFAULT_CNT_WIDTH = 16;

    // Width-generic saturating increment. Callers zero-extend their counter
    // into 64 bits and cast the result back down to their own width.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input int unsigned width);
        logic [63:0] max_value;
        if (width >= 64) begin
            max_value = '1;
        end else begin
            max_value = (64'd1 << width) - 64'd1;
        end
        return (value >= max_value) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/handshake_token_checker.sv
// Golden-value checker for the token sink: compares every accepted token
// against a fixed value, keeps a sticky mismatch flag and a saturating
// mismatch counter. Both are cleared only by reset.
module handshake_token_checker
    import handshake_sink_pkg::*;
#(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter int unsigned             CNT_WIDTH  = DEFAULT_CNT_WIDTH,
    parameter logic [DATA_WIDTH-1:0]   GOLDEN     = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  xfer,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  mismatch,
    output logic [CNT_WIDTH-1:0]  mismatch_count
);

    logic [63:0] count_ext;
    logic        bad_token;

    // Widen the counter for the shared saturating increment and flag bad tokens.
    always_comb begin
        count_ext                  = '0;
        count_ext[CNT_WIDTH-1:0]   = mismatch_count;
        bad_token                  = xfer && (data != GOLDEN);
    end

    // Sticky flag and saturating count of tokens differing from the golden value.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch       <= 1'b0;
            mismatch_count <= '0;
        end else if (bad_token) begin
            mismatch       <= 1'b1;
            mismatch_count <= CNT_WIDTH'(sat_inc(count_ext, CNT_WIDTH));
        end
    end

endmodule

// File: rtl/handshake_token_sink.sv
// Terminal consumer for one elastic (data + valid/ready) channel. Accepts one
// token at a time, holds it in a result register until the host acks it,
// counts accepted tokens and raises done after EXPECTED_TOKENS of them
// (EXPECTED_TOKENS = 0 means run forever).
// Optional golden-value checking is enabled by defining
// HANDSHAKE_TOKEN_SINK_CHECK_EN, which adds the mismatch/mismatch_count ports.
module handshake_token_sink
    import handshake_sink_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH,
    parameter int unsigned EXPECTED_TOKENS = 1,
    parameter logic [31:0] CHECK_VALUE     = 32'h0000064E
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    input  logic                  result_ack,
    output logic [CNT_WIDTH-1:0]  token_count,
    output logic                  done
`ifdef HANDSHAKE_TOKEN_SINK_CHECK_EN
    ,
    output logic                  mismatch,
    output logic [CNT_WIDTH-1:0]  mismatch_count
`endif
);

    // Largest value the token counter can hold; a target beyond it can never
    // be matched, so done is disabled rather than compared against a
    // truncated target.
    localparam longint unsigned      CNT_MAX  = (64'd1 << CNT_WIDTH) - 64'd1;
    localparam bit                   EXP_FITS = longint'(EXPECTED_TOKENS) <= CNT_MAX;
    localparam bit                   DONE_EN  = (EXPECTED_TOKENS != 0) && EXP_FITS;
    localparam logic [CNT_WIDTH-1:0] EXP_CNT  = CNT_WIDTH'(EXPECTED_TOKENS);

    sink_state_t          state;
    sink_state_t          state_next;
    logic                 ready_state;
    logic                 xfer;
    logic [63:0]          count_ext;
    logic [CNT_WIDTH-1:0] count_inc;

    // ready comes from the state register only; rst masks it during the
    // reset cycle so an in-flight token is not considered transferred.
    always_comb begin
        ins_ready = ready_state && !rst;
        xfer      = ins_valid && ins_ready;
    end

    // Saturating next value of the token counter.
    always_comb begin
        count_ext                = '0;
        count_ext[CNT_WIDTH-1:0] = token_count;
        count_inc                = CNT_WIDTH'(sat_inc(count_ext, CNT_WIDTH));
    end

    // State, result capture and token counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACCEPT;
            result      <= '0;
            token_count <= '0;
        end else begin
            state <= state_next;
            if (xfer) begin
                result      <= ins;
                token_count <= count_inc;
            end
        end
    end

    // Next-state logic and output decode.
    always_comb begin
        state_next   = state;
        ready_state  = 1'b0;
        result_valid = 1'b0;
        done         = 1'b0;
        unique case (state)
            ACCEPT: begin
                ready_state = 1'b1;
                if (xfer) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                result_valid = 1'b1;
                if (result_ack) begin
                    if (DONE_EN && (token_count == EXP_CNT)) begin
                        state_next = DONE;
                    end else begin
                        state_next = ACCEPT;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                state_next = ACCEPT;
            end
        endcase
    end

    // Flag a token target the counter cannot reach (done would never assert).
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (EXP_FITS)
            else $error("handshake_token_sink: EXPECTED_TOKENS=%0d exceeds %0d-bit counter",
                        EXPECTED_TOKENS, CNT_WIDTH);
        end
    end

`ifdef HANDSHAKE_TOKEN_SINK_CHECK_EN
    handshake_token_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .GOLDEN     (DATA_WIDTH'(CHECK_VALUE))
    ) u_checker (
        .clk            (clk),
        .rst            (rst),
        .xfer           (xfer),
        .data           (ins),
        .mismatch       (mismatch),
        .mismatch_count (mismatch_count)
    );
`else
    // Checking disabled: no comparator and no extra ports.
`endif

endmodule

// File: doc/handshake_token_sink.md
Name: handshake_token_sink

Overview:
- Terminal consumer for one Dynamatic-style elastic channel (data + valid/ready): the receiving end of the channel that a constant or compute unit drives.
- Accepts tokens one at a time and holds each in a result register until a host-side ack.
- Counts accepted tokens and asserts `done` once a configured number has been consumed.
- Sits at the circuit boundary in place of the end/exit unit; used for silicon bring-up and simulation of generated dataflow kernels.

Parameters:
- DATA_WIDTH, 32, width of `ins` and `result`.
- CNT_WIDTH, 16, width of `token_count`.
- EXPECTED_TOKENS, 1, number of tokens after which `done` asserts; 0 = unlimited, `done` never asserts.
- CHECK_VALUE, 32'h0000064E, golden value compared against each token (used only with the optional feature).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- ins  in  DATA_WIDTH  token data.
- ins_valid  in  1  token present.
- ins_ready  out  1  sink can accept.
- result  out  DATA_WIDTH  last accepted token.
- result_valid  out  1  `result` holds an unacknowledged token.
- result_ack  in  1  host consumes `result` (single-cycle pulse or level).
- token_count  out  CNT_WIDTH  tokens accepted since reset.
- done  out  1  EXPECTED_TOKENS reached.

Behaviour:
- Transfer: xfer = ins_valid & ins_ready. `ins_ready` is decoded from registered state only, so there is no combinational path from `ins_valid` or `result_ack`.
- States:
  - ACCEPT: ins_ready=1, result_valid=0.
  - HOLD: ins_ready=0, result_valid=1.
  - DONE: ins_ready=0, result_valid=0, done=1.
- ACCEPT, on xfer:
  - result <= ins.
  - token_count <= token_count+1, saturating at all-ones.
  - Next state HOLD; result_valid is 1 in the next cycle, so latency is 1 cycle.
- ACCEPT, no xfer: stay. A `result_ack` arriving in ACCEPT is ignored.
- HOLD:
  - No `result_ack`: stay; `result` stable. A token on `ins` stays valid upstream (backpressure).
  - On `result_ack`: if EXPECTED_TOKENS!=0 and token_count==EXPECTED_TOKENS, go to DONE; otherwise go to ACCEPT.
  - Consequence: at most one token is accepted every 2 cycles. That throughput is acceptable at a sink.
- DONE: absorbing until rst. Further `ins_valid` is never accepted; `token_count` is frozen.
- Count comparison: zero-extend EXPECTED_TOKENS to CNT_WIDTH. If EXPECTED_TOKENS > 2^CNT_WIDTH-1, the count saturates and `done` never asserts. This is an elaboration-time error, reported by assertion in simulation.
- Reset values (rst=1 at a clock edge, overriding everything including an in-flight xfer):
  - state=ACCEPT, result=0, result_valid=0, token_count=0, done=0.
  - ins_ready=0 during the rst cycle itself; 1 from the first cycle after rst deasserts.
- Reset while in HOLD or DONE: the held token is discarded and counts are cleared.
- `ins` is sampled only on xfer. X on `ins` while ins_valid=0 must not propagate.

Optional Feature:
- Macro HANDSHAKE_TOKEN_SINK_CHECK_EN.
- When defined:
  - Adds output `mismatch` (1 bit, sticky), reset 0.
  - Set on any xfer where ins != CHECK_VALUE[DATA_WIDTH-1:0]; cleared only by rst.
  - Adds output `mismatch_count` (CNT_WIDTH, saturating), incremented on the same condition.
- When undefined: both ports are absent and there is no comparison logic; all other behaviour is identical.

Decomposition:
- Shared package handshake_sink_pkg:
  - State enum {ACCEPT, HOLD, DONE} (2-bit encoding).
  - Default CNT_WIDTH constant.
  - Saturating-increment function, reused by both counters.
- Optional sub-module handshake_token_checker: comparator plus sticky flag plus counter, instantiated only under HANDSHAKE_TOKEN_SINK_CHECK_EN.
- The main FSM stays in the top module.

Test Plan:
- Reset/idle: hold rst 3 cycles, then release → ins_ready=1 from the first post-reset cycle; result=0, token_count=0, done=0.
- Single token (EXPECTED_TOKENS=1, DATA_WIDTH=12):
  - Drive ins=12'h64E with valid → next cycle result=12'h64E, result_valid=1, ins_ready=0, token_count=1.
  - Ack → DONE: done=1, ins_ready stays 0.
- Backpressure (EXPECTED_TOKENS=3):
  - Hold ins_valid=1 with values 5, 6, 7 and delay each ack by 4 cycles.
  - Each value is captured exactly once and in order; ins_ready stays low for the full hold period.
  - done=1 after the third ack; a fourth token is never accepted.
- Unlimited (EXPECTED_TOKENS=0, CNT_WIDTH=4): stream 20 tokens with immediate acks → token_count saturates at 15 and done stays 0.
- Reset mid-HOLD: capture 0xAB, then assert rst before the ack → result=0, result_valid=0, token_count=0; the next token is accepted normally.
- CHECK_EN (CHECK_VALUE=0x64E): tokens 0x64E, 0x64F, 0x64E → mismatch rises after the second xfer and stays 1; mismatch_count=1.
